// File: rtl/clk_div_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : clk_div_ctrl
//  Description : Programmable clock-enable controller. Produces a registered
//                divided clock (div_clk) and a one-cycle period-start strobe
//                (div_en) from clk, with a divide ratio that can be changed at
//                runtime. Ratio changes and stop requests take effect only at
//                period boundaries, so div_clk never carries a truncated pulse.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
//  Ports
//    clk        in   system clock
//    rst        in   synchronous, active-high reset
//    run        in   level request to generate the divided clock
//    cfg_valid  in   a new ratio is offered on cfg_div
//    cfg_div    in   offered ratio N (legal range 2 .. 2^WIDTH-1)
//    cfg_ready  out  controller can accept a ratio
//    cfg_err    out  one-cycle pulse when an offered ratio is rejected
//    div_clk    out  registered divided clock (high ceil(N/2), low floor(N/2))
//    div_en     out  one-cycle pulse in the first cycle of each period
//    busy       out  controller is not idle
//    cur_div    out  ratio currently in effect
//  Parameters
//    WIDTH        width of the divide ratio
//    DEFAULT_DIV  ratio loaded at reset; must lie in 2 .. 2^WIDTH-1
//==============================================================================
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_clk,
    output logic             div_en,
    output logic             busy,
    output logic [WIDTH-1:0] cur_div
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [1:0]       c_ST_IDLE     = 2'd0;
    localparam logic [1:0]       c_ST_RUN      = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN    = 2'd2;
    localparam logic [WIDTH-1:0] c_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_MIN_DIV     = WIDTH'(2);

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_div_clk;
    logic             r_div_en;
    logic             r_cfg_err;
    logic             r_cfg_ready;
    logic             r_busy;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_vld;

    //--------------------------------------------------------------------------
    // Combinational signals
    //--------------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic             w_xfer;
    logic             w_cfg_bad;
    logic             w_cfg_ok;
    logic             w_active;
    logic             w_wrap;
    logic [WIDTH:0]   w_half;        // ceil(N/2), one bit wider to hold N=2^WIDTH-1
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_div_clk_nxt;
    logic             w_div_en_nxt;
    logic             w_cfg_err_nxt;
    logic             w_cfg_ready_nxt;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] w_cur_div_nxt;
    logic [WIDTH-1:0] w_pend_div_nxt;
    logic             w_pend_vld_nxt;

    assign w_xfer    = cfg_valid && r_cfg_ready;
    assign w_cfg_bad = w_xfer && (cfg_div < c_MIN_DIV);
    assign w_cfg_ok  = w_xfer && !(cfg_div < c_MIN_DIV);
    assign w_active  = (r_state != c_ST_IDLE);

    // cur_div is never below 2, so N-1 cannot underflow.
    assign w_wrap    = w_active && (r_cnt == (r_cur_div - 1'b1));
    assign w_half    = ({1'b0, r_cur_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;

    //--------------------------------------------------------------------------
    // FSM process 1: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // RUN and DRAIN share the same rule: a high run keeps (or returns to)
    // RUN, a low run waits for the wrap edge before going idle.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (run) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN, c_ST_DRAIN: begin
                if (run) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_wrap) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM process 3: output / datapath next values
    // All outputs are registered; this block computes what they take on the
    // coming edge.
    //--------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_div_clk_nxt   = r_div_clk;
        w_div_en_nxt    = 1'b0;
        w_cfg_err_nxt   = w_cfg_bad;
        w_cfg_ready_nxt = r_cfg_ready;
        w_busy_nxt      = (w_state_nxt != c_ST_IDLE);
        w_cur_div_nxt   = r_cur_div;
        w_pend_div_nxt  = r_pend_div;
        w_pend_vld_nxt  = r_pend_vld;

        case (r_state)
            c_ST_IDLE: begin
                // Ratio accepted here is used by a period starting on this
                // same edge.
                if (w_cfg_ok) begin
                    w_cur_div_nxt = cfg_div;
                end
                w_cnt_nxt     = '0;
                w_div_en_nxt  = (w_state_nxt == c_ST_RUN);
                w_div_clk_nxt = (w_state_nxt == c_ST_RUN);
            end

            c_ST_RUN, c_ST_DRAIN: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_pend_vld) begin
                        w_cur_div_nxt   = r_pend_div;
                        w_pend_vld_nxt  = 1'b0;
                        w_cfg_ready_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end

                // A transfer only happens while nothing is pending, so a
                // ratio taken on a wrap edge is held for the following wrap.
                if (w_cfg_ok) begin
                    w_pend_div_nxt  = cfg_div;
                    w_pend_vld_nxt  = 1'b1;
                    w_cfg_ready_nxt = 1'b0;
                end

                if (w_state_nxt == c_ST_IDLE) begin
                    w_div_en_nxt  = 1'b0;
                    w_div_clk_nxt = 1'b0;
                end else begin
                    // At a wrap the next count is 0, which is high for any
                    // N, so the old ratio's half-point is safe to use here.
                    w_div_en_nxt  = (w_cnt_nxt == '0);
                    w_div_clk_nxt = ({1'b0, w_cnt_nxt} < w_half);
                end
            end

            default: begin
                w_cnt_nxt     = '0;
                w_div_clk_nxt = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath / output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_div_clk   <= 1'b0;
            r_div_en    <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_cur_div   <= c_DEFAULT_DIV;
            r_pend_div  <= c_DEFAULT_DIV;
            r_pend_vld  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_div_clk   <= w_div_clk_nxt;
            r_div_en    <= w_div_en_nxt;
            r_cfg_err   <= w_cfg_err_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_cur_div   <= w_cur_div_nxt;
            r_pend_div  <= w_pend_div_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign div_clk   = r_div_clk;
    assign div_en    = r_div_en;
    assign busy      = r_busy;
    assign cur_div   = r_cur_div;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : tb_clk_div_ctrl
//  Description : Self-checking bench for clk_div_ctrl. A period-level model
//                (on/off, position in period, ratio, pending ratio) predicts
//                every output after each clock edge; directed steps cover the
//                listed scenarios, followed by a randomized run.
//  Revision    : 1.0 - initial release
//==============================================================================
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       div_clk;
    logic       div_en;
    logic       busy;
    logic [7:0] cur_div;

    clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .div_en    (div_en),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: period-level view of the controller.
    bit m_on    = 0;    // generating periods
    int m_pos   = 0;    // cycle index inside the current period
    int m_n     = 2;    // ratio in effect
    int m_pend  = -1;   // pending ratio, -1 when none
    bit m_ready = 1;
    bit m_err   = 0;

    function automatic bit m_clk();
        return m_on && (m_pos < (m_n + 1) / 2);
    endfunction

    function automatic bit m_en();
        return m_on && (m_pos == 0);
    endfunction

    task automatic model_edge(input bit r, input bit ru, input bit v, input int d);
        bit acc;
        bit bad;
        if (r) begin
            m_on = 0; m_pos = 0; m_n = 2; m_pend = -1; m_ready = 1; m_err = 0;
            return;
        end
        acc   = v && m_ready;
        bad   = acc && (d < 2);
        m_err = bad;
        if (!m_on) begin
            if (acc && !bad) m_n = d;
            if (ru) begin
                m_on  = 1;
                m_pos = 0;
            end
        end else begin
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (m_pend >= 0) begin
                    m_n     = m_pend;
                    m_pend  = -1;
                    m_ready = 1;
                end
                if (!ru) m_on = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (acc && !bad) begin
                m_pend  = d;
                m_ready = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Apply inputs, clock one edge, then compare all outputs with the model.
    task automatic step(input bit r, input bit ru, input bit v, input int d);
        rst       = r;
        run       = ru;
        cfg_valid = v;
        cfg_div   = 8'(d);
        @(posedge clk);
        cyc++;
        model_edge(r, ru, v, d);
        #1;
        chk("div_clk",   {31'd0, div_clk},   {31'd0, m_clk()});
        chk("div_en",    {31'd0, div_en},    {31'd0, m_en()});
        chk("busy",      {31'd0, busy},      {31'd0, m_on});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, m_ready});
        chk("cfg_err",   {31'd0, cfg_err},   {31'd0, m_err});
        chk("cur_div",   {24'd0, cur_div},   32'(m_n));
    endtask

    task automatic go_idle();
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (!m_on) begin ok = 1; break; end
            step(0, 0, 0, 0);
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $error("FAIL go_idle timeout cyc=%0d got=busy expected=idle", cyc);
        end
    endtask

    task automatic wait_pos(input int p);
        bit ok = 0;
        for (int k = 0; k < 300; k++) begin
            if (m_on && m_pos == p) begin ok = 1; break; end
            step(0, 1, 0, 0);
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $error("FAIL wait_pos timeout cyc=%0d got=%0d expected=%0d", cyc, m_pos, p);
        end
    endtask

    initial begin
        int pat5 [5] = '{1, 1, 1, 0, 0};
        int pat3 [3] = '{1, 1, 0};
        bit ru;

        rst = 1; run = 0; cfg_valid = 0; cfg_div = '0;

        // 1. Reset defaults, then N=2 toggling.
        repeat (3) step(1, 0, 0, 0);
        chk("t1_rst_cur",   {24'd0, cur_div},   32'd2);
        chk("t1_rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t1_rst_clk",   {31'd0, div_clk},   32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            chk("t1_clk", {31'd0, div_clk}, 32'((i % 2) == 0));
            chk("t1_en",  {31'd0, div_en},  32'((i % 2) == 0));
        end

        // 2. Odd ratio loaded in IDLE.
        go_idle();
        step(0, 0, 1, 5);
        chk("t2_cur", {24'd0, cur_div}, 32'd5);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            chk("t2_clk",   {31'd0, div_clk},   32'(pat5[i % 5]));
            chk("t2_en",    {31'd0, div_en},    32'((i % 5) == 0));
            chk("t2_ready", {31'd0, cfg_ready}, 32'd1);
        end

        // 3. Mid-run change 4 -> 3 offered at cnt=1.
        go_idle();
        step(0, 0, 1, 4);
        step(0, 1, 0, 0);
        wait_pos(1);
        step(0, 1, 1, 3);                       // cnt -> 2
        chk("t3_ready_lo", {31'd0, cfg_ready}, 32'd0);
        chk("t3_cur_old",  {24'd0, cur_div},   32'd4);
        step(0, 1, 0, 0);                       // cnt -> 3
        chk("t3_ready_lo2", {31'd0, cfg_ready}, 32'd0);
        chk("t3_clk_lo",    {31'd0, div_clk},   32'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            chk("t3_clk",   {31'd0, div_clk},   32'(pat3[i % 3]));
            chk("t3_en",    {31'd0, div_en},    32'((i % 3) == 0));
            chk("t3_cur",   {24'd0, cur_div},   32'd3);
            chk("t3_ready", {31'd0, cfg_ready}, 32'd1);
        end

        // 4. Illegal ratios: 1 while running, 0 in IDLE.
        step(0, 1, 1, 1);
        chk("t4_err_run", {31'd0, cfg_err}, 32'd1);
        chk("t4_cur_run", {24'd0, cur_div}, 32'd3);
        step(0, 1, 0, 0);
        chk("t4_err_clr", {31'd0, cfg_err}, 32'd0);
        go_idle();
        step(0, 0, 1, 0);
        chk("t4_err_idle", {31'd0, cfg_err}, 32'd1);
        chk("t4_cur_idle", {24'd0, cur_div}, 32'd3);
        step(0, 0, 0, 0);
        chk("t4_err_clr2", {31'd0, cfg_err}, 32'd0);

        // 5. Stop at cnt=2 of N=6, then stop-and-resume at cnt=4.
        step(0, 0, 1, 6);
        step(0, 1, 0, 0);
        wait_pos(2);
        step(0, 0, 0, 0);
        chk("t5_busy3", {31'd0, busy}, 32'd1);
        step(0, 0, 0, 0);
        chk("t5_busy4", {31'd0, busy}, 32'd1);
        step(0, 0, 0, 0);
        chk("t5_busy5", {31'd0, busy}, 32'd1);
        step(0, 0, 0, 0);
        chk("t5_idle_busy", {31'd0, busy},    32'd0);
        chk("t5_idle_clk",  {31'd0, div_clk}, 32'd0);
        step(0, 1, 0, 0);
        wait_pos(2);
        step(0, 0, 0, 0);                       // cnt -> 3
        step(0, 0, 0, 0);                       // cnt -> 4
        step(0, 1, 0, 0);                       // run back at cnt=4 -> cnt 5
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0);
            chk("t5_res_en",   {31'd0, div_en}, 32'((i % 6) == 0));
            chk("t5_res_busy", {31'd0, busy},   32'd1);
        end

        // 6. Reset at cnt=3 of N=7 with 9 pending.
        go_idle();
        step(0, 0, 1, 7);
        step(0, 1, 0, 0);
        step(0, 1, 1, 9);
        chk("t6_pend", {31'd0, cfg_ready}, 32'd0);
        wait_pos(3);
        step(1, 1, 0, 0);
        chk("t6_busy",  {31'd0, busy},      32'd0);
        chk("t6_clk",   {31'd0, div_clk},   32'd0);
        chk("t6_en",    {31'd0, div_en},    32'd0);
        chk("t6_cur",   {24'd0, cur_div},   32'd2);
        chk("t6_ready", {31'd0, cfg_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            chk("t6_clk2", {31'd0, div_clk}, 32'((i % 2) == 0));
            chk("t6_cur2", {24'd0, cur_div}, 32'd2);
        end

        // Randomized run against the model.
        ru = 1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) ru = ~ru;
            step($urandom_range(0, 149) == 0, ru,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 9)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
